// File: rtl/fetch_unit_if.sv
// Bundle of the fetch front-end signals: the instruction-memory request /
// response channel, the decode-side delivery channel and the control-unit
// redirect.
//   master : the fetch unit (drives imem request and instr delivery)
//   slave  : the environment (memory, decode stage, control unit)
// Signals:
//   imem_req_valid / imem_req_ready / imem_addr : word-aligned fetch request
//   imem_rsp_valid / imem_rsp_data              : in-order fetch response
//   instr_valid / instr_ready / instr / instr_pc: buffered instruction head
//   PCSrc / PCTarget                            : one-cycle redirect request
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            PCSrc;
  logic [XLEN-1:0] PCTarget;

  modport master (
    output imem_req_valid, imem_addr, instr_valid, instr, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
    input  PCSrc, PCTarget
  );

  modport slave (
    input  imem_req_valid, imem_addr, instr_valid, instr, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
    output PCSrc, PCTarget
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front-end. Owns the PC, issues word-aligned requests to
// instruction memory, tags each in-flight request with its address and
// buffers returned words with their PC for decode. A redirect reloads the PC,
// clears the buffer and arranges for still-outstanding responses to be
// dropped as they arrive.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : fetch_unit_if.master (imem request/response, instr delivery,
//           PCSrc/PCTarget redirect)
// Parameters: XLEN (data/address width), RESET_PC (word aligned),
//             DEPTH (power of two >= 2; buffered + in-flight limit).
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
  parameter int              DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int CW1 = CW + 1;
  localparam logic [CW1-1:0] DEPTH_W = CW1'(DEPTH);
  localparam logic [CW-1:0]  C_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0]  C_ONE   = CW'(1'b1);
  localparam logic [PW-1:0]  P_ZERO  = {PW{1'b0}};
  localparam logic [PW-1:0]  P_ONE   = PW'(1'b1);

  logic [XLEN-1:0] pc_r;
  logic [CW-1:0]   inflight_r;
  logic [CW-1:0]   discard_r;
  logic [CW-1:0]   count_r;
  logic [XLEN-1:0] tag_mem_r   [DEPTH];
  logic [PW-1:0]   tag_wr_r;
  logic [PW-1:0]   tag_rd_r;
  logic [XLEN-1:0] buf_pc_r    [DEPTH];
  logic [XLEN-1:0] buf_instr_r [DEPTH];
  logic [PW-1:0]   buf_wr_r;
  logic [PW-1:0]   buf_rd_r;

  logic [CW1-1:0]  occupancy_s;
  logic            room_s;
  logic            req_fire_s;
  logic            rsp_acc_s;
  logic            push_s;
  logic            pop_s;
  logic [CW-1:0]   inflight_nx_s;
  logic [CW-1:0]   discard_nx_s;
  logic [CW-1:0]   count_nx_s;
  logic [XLEN-1:0] target_s;

  // Handshake qualifiers; a response with nothing in flight is ignored.
  always_comb begin
    occupancy_s = {1'b0, inflight_r} + {1'b0, count_r};
    room_s      = (occupancy_s < DEPTH_W);
    req_fire_s  = bus.imem_req_valid && bus.imem_req_ready;
    rsp_acc_s   = bus.imem_rsp_valid && (inflight_r != C_ZERO);
    push_s      = rsp_acc_s && !bus.PCSrc && (discard_r == C_ZERO);
    pop_s       = (count_r != C_ZERO) && bus.instr_ready;
    target_s    = bus.PCTarget & {{(XLEN-2){1'b1}}, 2'b00};
  end

  // rst_n gating keeps the request low for the whole reset assertion.
  assign bus.imem_req_valid = rst_n && !bus.PCSrc && room_s;
  assign bus.imem_addr      = pc_r;
  assign bus.instr_valid    = (count_r != C_ZERO);
  assign bus.instr          = buf_instr_r[buf_rd_r];
  assign bus.instr_pc       = buf_pc_r[buf_rd_r];

  // Next values of the in-flight, discard and buffer-occupancy counters.
  always_comb begin
    inflight_nx_s = inflight_r;
    discard_nx_s  = discard_r;
    count_nx_s    = count_r;
    if (req_fire_s && !rsp_acc_s) begin
      inflight_nx_s = inflight_r + C_ONE;
    end else if (!req_fire_s && rsp_acc_s) begin
      inflight_nx_s = inflight_r - C_ONE;
    end else begin
      inflight_nx_s = inflight_r;
    end
    // On redirect every request still unanswered after this edge is stale.
    if (bus.PCSrc) begin
      discard_nx_s = inflight_r - (rsp_acc_s ? C_ONE : C_ZERO);
    end else if (rsp_acc_s && (discard_r != C_ZERO)) begin
      discard_nx_s = discard_r - C_ONE;
    end else begin
      discard_nx_s = discard_r;
    end
    if (bus.PCSrc) begin
      count_nx_s = C_ZERO;
    end else if (push_s && !pop_s) begin
      count_nx_s = count_r + C_ONE;
    end else if (!push_s && pop_s) begin
      count_nx_s = count_r - C_ONE;
    end else begin
      count_nx_s = count_r;
    end
  end

  // PC register: redirect wins, otherwise advance on each accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= RESET_PC;
    end else if (bus.PCSrc) begin
      pc_r <= target_s;
    end else if (req_fire_s) begin
      pc_r <= pc_r + XLEN'(3'd4);
    end else begin
      pc_r <= pc_r;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_r <= C_ZERO;
      discard_r  <= C_ZERO;
      count_r    <= C_ZERO;
    end else begin
      inflight_r <= inflight_nx_s;
      discard_r  <= discard_nx_s;
      count_r    <= count_nx_s;
    end
  end

  // Tag FIFO: address of each outstanding request, popped by every accepted
  // response (stale ones included) so tags stay aligned with the memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tag_mem_r[i] <= {XLEN{1'b0}};
      end
      tag_wr_r <= P_ZERO;
      tag_rd_r <= P_ZERO;
    end else begin
      if (req_fire_s) begin
        tag_mem_r[tag_wr_r] <= pc_r;
        tag_wr_r            <= tag_wr_r + P_ONE;
      end
      if (rsp_acc_s) begin
        tag_rd_r <= tag_rd_r + P_ONE;
      end
    end
  end

  // Instruction buffer of {pc, instr}; a redirect empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_pc_r[i]    <= {XLEN{1'b0}};
        buf_instr_r[i] <= {XLEN{1'b0}};
      end
      buf_wr_r <= P_ZERO;
      buf_rd_r <= P_ZERO;
    end else if (bus.PCSrc) begin
      buf_wr_r <= P_ZERO;
      buf_rd_r <= P_ZERO;
    end else begin
      if (push_s) begin
        buf_pc_r[buf_wr_r]    <= tag_mem_r[tag_rd_r];
        buf_instr_r[buf_wr_r] <= bus.imem_rsp_data;
        buf_wr_r              <= buf_wr_r + P_ONE;
      end
      if (pop_s) begin
        buf_rd_r <= buf_rd_r + P_ONE;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. Two instances: dut0 (RESET_PC 0) runs
// directed and randomized phases against a memory model with variable
// latency; dut1 (RESET_PC FFFF_FFF8) streams continuously to show PC wrap.
// The reference model is the expected delivered-PC stream: consecutive words
// from the reset PC, restarting at the word-aligned target after a redirect.
`timescale 1ns/1ps
module tb_fetch_unit;
  localparam int          XLEN  = 32;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC0  = 32'h0000_0000;
  localparam logic [31:0] RPC1  = 32'hFFFF_FFF8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(XLEN)) bus0 ();
  fetch_unit_if #(.XLEN(XLEN)) bus1 ();

  fetch_unit #(.XLEN(XLEN), .RESET_PC(RPC0), .DEPTH(DEPTH)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );
  fetch_unit #(.XLEN(XLEN), .RESET_PC(RPC1), .DEPTH(DEPTH)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } req_t;

  req_t        mq[$];
  int unsigned cyc;
  logic [31:0] exp0, exp1;
  logic        pend1;
  logic [31:0] pend1_addr;
  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned rdy_pct, lat_min, lat_max, irdy_pct, redir_pct;
  bit          spur_en, coincide_en, redir2_en;
  bit          redir_prev, wait_prev, last_rv0;
  logic [31:0] redir_tgt_prev, addr_prev;
  int          n_issue, n_deliv0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus0.imem_req_ready = 1'b0; bus0.imem_rsp_valid = 1'b0; bus0.imem_rsp_data = 32'h0;
    bus0.instr_ready    = 1'b0; bus0.PCSrc = 1'b0;          bus0.PCTarget = 32'h0;
    bus1.imem_req_ready = 1'b0; bus1.imem_rsp_valid = 1'b0; bus1.imem_rsp_data = 32'h0;
    bus1.instr_ready    = 1'b0; bus1.PCSrc = 1'b0;          bus1.PCTarget = 32'h0;
  endtask

  // Assert rst_n between clock edges, check the immediate reset values,
  // clear the model, release mid-cycle and check the first request.
  task automatic do_reset(input bit check_full);
    @(negedge clk);
    #2;
    if (check_full) check_eq("full_before_rst", 32'(bus0.instr_valid), 32'd1);
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check_eq("rst_instr_valid", 32'(bus0.instr_valid), 32'd0);
    check_eq("rst_req_valid", 32'(bus0.imem_req_valid), 32'd0);
    check_eq("rst_instr", bus0.instr, 32'h0);
    check_eq("rst_instr_pc", bus0.instr_pc, 32'h0);
    check_eq("rst_addr", bus0.imem_addr, RPC0);
    check_eq("rst_req_valid1", 32'(bus1.imem_req_valid), 32'd0);
    check_eq("rst_addr1", bus1.imem_addr, RPC1);
    mq.delete();
    pend1 = 1'b0; pend1_addr = 32'h0;
    exp0 = RPC0; exp1 = RPC1;
    redir_prev = 1'b0; wait_prev = 1'b0; last_rv0 = 1'b0;
    cyc = 0; n_issue = 0; n_deliv0 = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check_eq("post_rst_req", 32'(bus0.imem_req_valid), 32'd1);
    check_eq("post_rst_addr", bus0.imem_addr, RPC0);
    check_eq("post_rst_addr1", bus1.imem_addr, RPC1);
  endtask

  // One clock cycle: drive inputs after the falling edge, sample #1 later,
  // check against the model and advance it for the coming rising edge.
  task automatic step();
    logic        rsp_real, redir;
    logic [31:0] tgt, a0, pc0, d0, a1, pc1, d1;
    logic        rv0, iv0, rv1, iv1;
    int unsigned lat;
    @(negedge clk);
    rsp_real = (mq.size() > 0) && (mq[0].due <= cyc);
    bus0.imem_rsp_valid = 1'b0;
    bus0.imem_rsp_data  = 32'h0;
    if (rsp_real) begin
      bus0.imem_rsp_valid = 1'b1;
      bus0.imem_rsp_data  = mem_word(mq[0].addr);
    end else if (spur_en && (mq.size() == 0) && ($urandom_range(0, 7) == 0)) begin
      bus0.imem_rsp_valid = 1'b1;
      bus0.imem_rsp_data  = 32'hDEAD_BEEF;
    end
    bus0.imem_req_ready = ($urandom_range(0, 99) < rdy_pct);
    bus0.instr_ready    = ($urandom_range(0, 99) < irdy_pct);
    redir = 1'b0;
    tgt   = $urandom;
    if (coincide_en && bus0.instr_valid && (bus0.instr_pc == 32'h8) && rsp_real) begin
      redir = 1'b1; tgt = 32'h43; bus0.instr_ready = 1'b1; coincide_en = 1'b0;
    end else if (redir2_en && (mq.size() == 2)) begin
      redir = 1'b1; tgt = 32'h100; redir2_en = 1'b0;
    end else if ($urandom_range(0, 99) < redir_pct) begin
      redir = 1'b1;
    end
    bus0.PCSrc    = redir;
    bus0.PCTarget = tgt;
    bus1.imem_rsp_valid = pend1;
    bus1.imem_rsp_data  = mem_word(pend1_addr);
    bus1.imem_req_ready = 1'b1;
    bus1.instr_ready    = 1'b1;
    bus1.PCSrc          = 1'b0;
    bus1.PCTarget       = 32'h0;
    #1;
    rv0 = bus0.imem_req_valid; a0 = bus0.imem_addr;
    iv0 = bus0.instr_valid;    pc0 = bus0.instr_pc; d0 = bus0.instr;
    rv1 = bus1.imem_req_valid; a1 = bus1.imem_addr;
    iv1 = bus1.instr_valid;    pc1 = bus1.instr_pc; d1 = bus1.instr;

    if (redir_prev) begin
      check_eq("redir_no_instr", 32'(iv0), 32'd0);
      check_eq("redir_addr", a0, redir_tgt_prev & 32'hFFFF_FFFC);
    end
    if (redir) check_eq("redir_no_req", 32'(rv0), 32'd0);
    if (wait_prev && !redir) begin
      check_eq("req_hold_valid", 32'(rv0), 32'd1);
      check_eq("req_hold_addr", a0, addr_prev);
    end
    check_eq("occupancy", 32'(mq.size() <= DEPTH), 32'd1);
    if (iv0 && bus0.instr_ready) begin
      check_eq("instr_pc", pc0, exp0);
      check_eq("instr", d0, mem_word(exp0));
      exp0 = exp0 + 32'd4;
      n_deliv0++;
    end
    if (rv0 && bus0.imem_req_ready) begin
      lat = $urandom_range(lat_min, lat_max);
      mq.push_back('{addr: a0, due: cyc + lat});
      n_issue++;
    end
    if (rsp_real) void'(mq.pop_front());
    if (redir) exp0 = tgt & 32'hFFFF_FFFC;
    redir_prev     = redir;
    redir_tgt_prev = tgt;
    wait_prev      = rv0 && !bus0.imem_req_ready && !redir;
    addr_prev      = a0;
    last_rv0       = rv0;

    if (iv1) begin
      check_eq("wrap_instr_pc", pc1, exp1);
      check_eq("wrap_instr", d1, mem_word(exp1));
      exp1 = exp1 + 32'd4;
    end
    pend1      = rv1;
    pend1_addr = a1;
    cyc++;
  endtask

  task automatic set_mode(input int unsigned rdy, input int unsigned lmin, input int unsigned lmax,
                          input int unsigned irdy, input int unsigned rpct, input bit spur);
    rdy_pct = rdy; lat_min = lmin; lat_max = lmax; irdy_pct = irdy; redir_pct = rpct; spur_en = spur;
  endtask

  initial begin
    idle_inputs();
    coincide_en = 1'b0; redir2_en = 1'b0;
    set_mode(100, 1, 1, 100, 0, 1'b0);

    // Streaming from reset; redirect to 0x43 as head 0x8 pops and 0xC returns.
    do_reset(1'b0);
    coincide_en = 1'b1;
    repeat (30) step();
    check_eq("coincide_fired", 32'(coincide_en), 32'd0);
    check_eq("resumed_at_0x40", 32'(exp0 >= 32'h48), 32'd1);

    // Backpressure: decode stalls, at most DEPTH requests then request low.
    do_reset(1'b0);
    set_mode(100, 1, 1, 0, 0, 1'b0);
    repeat (12) step();
    check_eq("bp_issued", 32'(n_issue), 32'(DEPTH));
    check_eq("bp_req_low", 32'(last_rv0), 32'd0);
    set_mode(100, 1, 1, 100, 0, 1'b0);
    repeat (20) step();
    check_eq("bp_resumed", 32'(n_deliv0 >= 5), 32'd1);

    // Redirect to 0x100 with two requests in flight at 3-cycle latency.
    do_reset(1'b0);
    set_mode(100, 3, 3, 100, 0, 1'b0);
    redir2_en = 1'b1;
    repeat (40) step();
    check_eq("redir2_fired", 32'(redir2_en), 32'd0);
    check_eq("redir2_delivered", 32'(exp0 >= 32'h108), 32'd1);

    // Randomized traffic: stalls, latencies, redirects, spurious responses.
    do_reset(1'b0);
    set_mode(75, 1, 4, 70, 4, 1'b1);
    repeat (3000) step();
    check_eq("random_progress", 32'(n_deliv0 > 100), 32'd1);

    // Fill the buffer, then asynchronous reset mid-cycle and restart.
    set_mode(100, 1, 1, 0, 0, 1'b0);
    repeat (12) step();
    do_reset(1'b1);
    set_mode(100, 1, 1, 100, 0, 1'b0);
    repeat (20) step();
    check_eq("restart_progress", 32'(n_deliv0 >= 5), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
